// File: rtl/pl_mailbox_mem_if.sv
// PS/PL mailbox bus: PS register port, PL command port and the processor handshake.
interface pl_mailbox_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              ps_we;
  logic              ps_re;
  logic [ADDR_W-1:0] ps_addr;
  logic [DATA_W-1:0] ps_wdata;
  logic [DATA_W-1:0] ps_rdata;
  logic [2:0]        cmd;
  logic [ADDR_W-1:0] address_pl;
  logic [DATA_W-1:0] data_pl;
  logic [DATA_W-1:0] data_in;
  logic              done_pl;
  logic              ready;

  modport master (
    output ps_we, ps_re, ps_addr, ps_wdata, cmd, address_pl, data_pl, done_pl,
    input  ps_rdata, data_in, ready
  );

  modport slave (
    input  ps_we, ps_re, ps_addr, ps_wdata, cmd, address_pl, data_pl, done_pl,
    output ps_rdata, data_in, ready
  );
endinterface

// File: rtl/pl_mailbox_mem.sv
// Shared PS/PL mailbox: word array with job-load tracking and a small job FSM.
// Status at the top-3 slot is synthesized from FSM flags and never stored.
module pl_mailbox_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic clk,
  input  logic rst,
  pl_mailbox_mem_if.slave bus
);
  localparam logic [ADDR_W-1:0] A_OPS  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] A_BIAS = A_OPS - ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_INSN = A_OPS - ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_STAT = A_OPS - ADDR_W'(3);
  localparam logic [2:0]        CMD_WR = 3'd2;
  localparam logic [2:0]        CMD_RD = 3'd3;

  typedef enum logic [2:0] {IDLE, LOADING, READY_S, BUSY, DONE_S} state_t;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  state_t            state;
  logic [2:0]        mask;
  logic              ready_r;
  logic              busy;
  logic              done_flag;
  logic              done_q;

  logic       pl_wr;
  logic       pl_rd;
  logic       ps_wr_arr;
  logic       stat_ack;
  logic       done_rise;
  logic [2:0] ld_bits;

  function automatic logic [DATA_W-1:0] status_word(input logic d, input logic b, input logic r);
    status_word      = '0;
    status_word[2:0] = {d, b, r};
  endfunction

  assign pl_wr     = (bus.cmd == CMD_WR);
  assign pl_rd     = (bus.cmd == CMD_RD);
  // PL wins a same-address collision; status slot is never backed by storage
  assign ps_wr_arr = bus.ps_we && (bus.ps_addr != A_STAT) &&
                     !(pl_wr && (bus.address_pl == bus.ps_addr));
  assign stat_ack  = bus.ps_we && (bus.ps_addr == A_STAT) && bus.ps_wdata[0];
  assign done_rise = bus.done_pl && !done_q;
  assign ld_bits   = {bus.ps_we && (bus.ps_addr == A_INSN),
                      bus.ps_we && (bus.ps_addr == A_BIAS),
                      bus.ps_we && (bus.ps_addr == A_OPS)};
  assign bus.ready = ready_r;

  always_ff @(posedge clk) begin
    if (pl_wr)     mem[bus.address_pl] <= bus.data_pl;
    if (ps_wr_arr) mem[bus.ps_addr]    <= bus.ps_wdata;
  end

  // read ports: one-cycle latency, contents sampled before this edge's writes
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ps_rdata <= '0;
      bus.data_in  <= '0;
    end else begin
      if (bus.ps_re)
        bus.ps_rdata <= (bus.ps_addr == A_STAT) ? status_word(done_flag, busy, ready_r)
                                                : mem[bus.ps_addr];
      if (pl_rd)
        bus.data_in <= mem[bus.address_pl];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mask      <= '0;
      ready_r   <= 1'b0;
      busy      <= 1'b0;
      done_flag <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= bus.done_pl;
      case (state)
        IDLE: begin
          if (|ld_bits) begin
            mask  <= mask | ld_bits;
            state <= LOADING;
          end
        end
        LOADING: begin
          mask <= mask | ld_bits;
          if (mask == 3'b111) begin
            state   <= READY_S;
            ready_r <= 1'b1;
          end
        end
        READY_S: begin
          if (pl_rd && (bus.address_pl == A_OPS)) begin
            state <= BUSY;
            busy  <= 1'b1;
          end
        end
        BUSY: begin
          if (done_rise) begin
            state     <= DONE_S;
            mask      <= '0;
            ready_r   <= 1'b0;
            busy      <= 1'b0;
            done_flag <= 1'b1;
          end
        end
        DONE_S: begin
          if (stat_ack) begin
            state     <= IDLE;
            done_flag <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pl_mailbox_mem.sv
// Directed bench for pl_mailbox_mem: a vector table for the job flow plus
// hand sequences for collisions and reset during a job.
module tb_pl_mailbox_mem;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_fail = 0;

  pl_mailbox_mem_if #(.DATA_W(32), .ADDR_W(8)) bus ();

  pl_mailbox_mem #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, we, re;
    logic [7:0]  paddr;
    logic [31:0] wdata;
    logic [2:0]  cmd;
    logic [7:0]  laddr;
    logic [31:0] ldata;
    logic        done;
    logic        exp_ready;
    logic        ck_r;
    logic [31:0] exp_r;
    logic        ck_d;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic r, we, re, input logic [7:0] pa, input logic [31:0] wd,
                             input logic [2:0] c, input logic [7:0] la, input logic [31:0] ld,
                             input logic dn, input logic er, input logic cr, input logic [31:0] xr,
                             input logic cd, input logic [31:0] xd);
    vec_t t;
    t.rst = r; t.we = we; t.re = re; t.paddr = pa; t.wdata = wd; t.cmd = c;
    t.laddr = la; t.ldata = ld; t.done = dn; t.exp_ready = er;
    t.ck_r = cr; t.exp_r = xr; t.ck_d = cd; t.exp_d = xd;
    return t;
  endfunction

  task automatic drive(input logic r, we, re, input logic [7:0] pa, input logic [31:0] wd,
                       input logic [2:0] c, input logic [7:0] la, input logic [31:0] ld,
                       input logic dn);
    @(negedge clk);
    rst = r; bus.ps_we = we; bus.ps_re = re; bus.ps_addr = pa; bus.ps_wdata = wd;
    bus.cmd = c; bus.address_pl = la; bus.data_pl = ld; bus.done_pl = dn;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle(input logic re, input logic [7:0] pa);
    drive(1'b0, 1'b0, re, pa, 32'h0, 3'd0, 8'd0, 32'h0, 1'b0);
  endtask

  initial begin
    bus.ps_we = 1'b0; bus.ps_re = 1'b0; bus.ps_addr = '0; bus.ps_wdata = '0;
    bus.cmd = '0; bus.address_pl = '0; bus.data_pl = '0; bus.done_pl = 1'b0;

    //               rst we re paddr wdata         cmd la   ldata          dn  rdy ckr exp_r          ckd exp_d
    vecs.push_back(v(1, 0, 0, 8'd0,   32'h0,        0, 0,   32'h0,         0,  0, 1, 32'h0,         1, 32'h0));
    vecs.push_back(v(0, 0, 1, 8'd252, 32'h0,        0, 0,   32'h0,         0,  0, 1, 32'h0,         0, 32'h0));
    vecs.push_back(v(0, 1, 0, 8'd255, 32'h87654321, 0, 0,   32'h0,         0,  0, 0, 32'h0,         0, 32'h0));
    vecs.push_back(v(0, 1, 0, 8'd254, 32'h5,        0, 0,   32'h0,         0,  0, 0, 32'h0,         0, 32'h0));
    vecs.push_back(v(0, 1, 0, 8'd253, 32'h1,        0, 0,   32'h0,         0,  0, 0, 32'h0,         0, 32'h0));
    vecs.push_back(v(0, 0, 1, 8'd252, 32'h0,        0, 0,   32'h0,         0,  1, 1, 32'h0,         0, 32'h0));
    vecs.push_back(v(0, 0, 1, 8'd252, 32'h0,        0, 0,   32'h0,         0,  1, 1, 32'h1,         0, 32'h0));
    vecs.push_back(v(0, 1, 0, 8'd254, 32'h6,        0, 0,   32'h0,         0,  1, 0, 32'h0,         0, 32'h0));
    vecs.push_back(v(0, 0, 1, 8'd254, 32'h0,        0, 0,   32'h0,         0,  1, 1, 32'h6,         0, 32'h0));
    vecs.push_back(v(0, 0, 1, 8'd252, 32'h0,        3, 255, 32'h0,         0,  1, 1, 32'h1,         1, 32'h87654321));
    vecs.push_back(v(0, 0, 1, 8'd252, 32'h0,        0, 0,   32'h0,         0,  1, 1, 32'h3,         1, 32'h87654321));
    vecs.push_back(v(0, 0, 0, 8'd0,   32'h0,        2, 1,   32'h0A0B0C0D,  0,  1, 0, 32'h0,         0, 32'h0));
    vecs.push_back(v(0, 0, 1, 8'd252, 32'h0,        0, 0,   32'h0,         1,  0, 1, 32'h3,         0, 32'h0));
    vecs.push_back(v(0, 0, 1, 8'd252, 32'h0,        0, 0,   32'h0,         1,  0, 1, 32'h4,         0, 32'h0));
    vecs.push_back(v(0, 0, 1, 8'd1,   32'h0,        0, 0,   32'h0,         0,  0, 1, 32'h0A0B0C0D,  0, 32'h0));
    vecs.push_back(v(0, 1, 0, 8'd252, 32'h0,        0, 0,   32'h0,         0,  0, 0, 32'h0,         0, 32'h0));
    vecs.push_back(v(0, 0, 1, 8'd252, 32'h0,        0, 0,   32'h0,         0,  0, 1, 32'h4,         0, 32'h0));
    vecs.push_back(v(0, 1, 0, 8'd252, 32'h1,        0, 0,   32'h0,         0,  0, 0, 32'h0,         0, 32'h0));
    vecs.push_back(v(0, 0, 1, 8'd252, 32'h0,        0, 0,   32'h0,         0,  0, 1, 32'h0,         0, 32'h0));
    vecs.push_back(v(0, 1, 0, 8'd252, 32'h1,        0, 0,   32'h0,         0,  0, 0, 32'h0,         0, 32'h0));
    vecs.push_back(v(0, 0, 1, 8'd252, 32'h0,        0, 0,   32'h0,         0,  0, 1, 32'h0,         0, 32'h0));
    vecs.push_back(v(0, 0, 0, 8'd0,   32'h0,        3, 255, 32'h0,         0,  0, 0, 32'h0,         1, 32'h87654321));
    vecs.push_back(v(0, 0, 1, 8'd252, 32'h0,        0, 0,   32'h0,         1,  0, 1, 32'h0,         1, 32'h87654321));
    vecs.push_back(v(0, 0, 1, 8'd252, 32'h0,        1, 1,   32'h0000DEAD,  0,  0, 1, 32'h0,         1, 32'h87654321));
    vecs.push_back(v(0, 0, 1, 8'd1,   32'h0,        0, 0,   32'h0,         0,  0, 1, 32'h0A0B0C0D,  0, 32'h0));
    vecs.push_back(v(0, 1, 1, 8'd1,   32'h55,       0, 0,   32'h0,         0,  0, 1, 32'h0A0B0C0D,  0, 32'h0));
    vecs.push_back(v(0, 0, 1, 8'd1,   32'h0,        0, 0,   32'h0,         0,  0, 1, 32'h55,        0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].re, vecs[i].paddr, vecs[i].wdata,
            vecs[i].cmd, vecs[i].laddr, vecs[i].ldata, vecs[i].done);
      check($sformatf("v%0d_ready", i), {31'h0, bus.ready}, {31'h0, vecs[i].exp_ready});
      if (vecs[i].ck_r) check($sformatf("v%0d_ps_rdata", i), bus.ps_rdata, vecs[i].exp_r);
      if (vecs[i].ck_d) check($sformatf("v%0d_data_in", i), bus.data_in, vecs[i].exp_d);
    end

    // same-cycle PS and PL write to one address: PL data is kept
    drive(1'b0, 1'b1, 1'b0, 8'd1, 32'h11, 3'd2, 8'd1, 32'h22, 1'b0);
    idle(1'b1, 8'd1);
    check("collide_pl_wins", bus.ps_rdata, 32'h22);
    // PS read during a PL write to the same address sees the old word
    drive(1'b0, 1'b0, 1'b1, 8'd1, 32'h0, 3'd2, 8'd1, 32'h33, 1'b0);
    check("rbw_old", bus.ps_rdata, 32'h22);
    idle(1'b1, 8'd1);
    check("rbw_new", bus.ps_rdata, 32'h33);

    // reset in the middle of a job
    drive(1'b0, 1'b1, 1'b0, 8'd255, 32'h87654321, 3'd0, 8'd0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'd254, 32'h5, 3'd0, 8'd0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'd253, 32'h1, 3'd0, 8'd0, 32'h0, 1'b0);
    idle(1'b0, 8'd0);
    check("job2_ready", {31'h0, bus.ready}, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 32'h0, 3'd3, 8'd255, 32'h0, 1'b0);
    check("job2_data_in", bus.data_in, 32'h87654321);
    idle(1'b1, 8'd252);
    check("job2_busy_status", bus.ps_rdata, 32'h3);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 32'h0, 3'd0, 8'd0, 32'h0, 1'b0);
    check("rst_ready", {31'h0, bus.ready}, 32'h0);
    check("rst_ps_rdata", bus.ps_rdata, 32'h0);
    check("rst_data_in", bus.data_in, 32'h0);
    idle(1'b1, 8'd252);
    check("rst_status", bus.ps_rdata, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 32'h0, 3'd0, 8'd0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 8'd252, 32'h0, 3'd0, 8'd0, 32'h0, 1'b1);
    check("post_rst_done_ignored", bus.ps_rdata, 32'h0);
    check("post_rst_ready", {31'h0, bus.ready}, 32'h0);
    idle(1'b1, 8'd255);
    check("array_kept", bus.ps_rdata, 32'h87654321);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
